// File: rtl/lsu_bus_master.sv
// lsu_bus_master: single-beat req/ack load/store unit with lane steering and load extension.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of force-aligning them.
module lsu_bus_master #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_dmem_rd_en,
  input  logic              i_dmem_wr_en,
  input  logic              i_dmem_zero_ext,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic [31:0]       o_rdata,
  output logic              o_rdata_valid,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_wmask,
  input  logic              i_bus_ack,
`ifdef LSU_MISALIGN_TRAP_EN
  input  logic [31:0]       i_bus_rdata,
  output logic              o_misaligned
`else
  input  logic [31:0]       i_bus_rdata
`endif
);
`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
`endif
  state_t      r_state;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_zext;
  logic        w_start;
  logic [31:0] w_st_data;
  logic [3:0]  w_st_mask;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_ld;
  assign w_start   = i_valid & (i_dmem_rd_en | i_dmem_wr_en);
  assign o_stall   = (r_state == S_IDLE & w_start) | (r_state == S_REQ);
  assign w_st_data = i_size[1] ? i_wdata : i_size[0] ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
  assign w_st_mask = i_size[1] ? 4'b1111 : i_size[0] ? (i_addr[1] ? 4'b1100 : 4'b0011)
                                                      : 4'b0001 << i_addr[1:0];
  // Load lanes come from the captured address, since i_addr may change while stalled
  assign w_b  = r_lane[1] ? (r_lane[0] ? i_bus_rdata[31:24] : i_bus_rdata[23:16])
                          : (r_lane[0] ? i_bus_rdata[15:8]  : i_bus_rdata[7:0]);
  assign w_h  = r_lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
  assign w_ld = r_size[1] ? i_bus_rdata
              : r_size[0] ? {{16{~r_zext & w_h[15]}}, w_h}
                          : {{24{~r_zext & w_b[7]}}, w_b};
`ifdef LSU_MISALIGN_TRAP_EN
  logic w_mis;
  assign w_mis = (i_size == 2'b01 & i_addr[0]) | (i_size[1] & |i_addr[1:0]);
`endif
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_lane        <= '0;
      r_size        <= '0;
      r_zext        <= 1'b0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_bus_req     <= 1'b0;
      o_bus_we      <= 1'b0;
      o_bus_addr    <= '0;
      o_bus_wdata   <= '0;
      o_bus_wmask   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      o_misaligned  <= 1'b0;
`endif
    end else begin
      o_rdata_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      o_misaligned  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: if (w_start) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (w_mis) begin
            r_state      <= S_ERR;
            o_misaligned <= 1'b1;
          end else
`endif
          begin
            r_state     <= S_REQ;
            r_lane      <= i_addr[1:0];
            r_size      <= i_size;
            r_zext      <= i_dmem_zero_ext;
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_dmem_wr_en;
            o_bus_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
            o_bus_wdata <= w_st_data;
            o_bus_wmask <= i_dmem_wr_en ? w_st_mask : 4'b0000;
          end
        end
        S_REQ: if (i_bus_ack) begin
          r_state       <= S_DONE;
          o_bus_req     <= 1'b0;
          o_rdata       <= o_bus_we ? o_rdata : w_ld;
          o_rdata_valid <= ~o_bus_we;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

Load/store unit sitting between the execute stage and the data-memory bus. It consumes the data-memory control fields produced by the instruction decoder (read enable, write enable, zero-extend, access size from funct3) plus the ALU-computed address and rs2 store data. It issues single-beat requests on a req/ack memory bus and returns aligned, sign- or zero-extended load data to write-back. It stalls the pipeline while a bus transaction is outstanding.

## Interface
- ADDR_W, 32, byte-address width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  instruction in execute is valid
- i_dmem_rd_en  in  1  load request (decoder)
- i_dmem_wr_en  in  1  store request (decoder)
- i_dmem_zero_ext  in  1  1 = zero-extend load, 0 = sign-extend
- i_size  in  2  funct3[1:0]: 00 byte, 01 half, 10/11 word
- i_addr  in  ADDR_W  byte address
- i_wdata  in  32  store data (rs2)
- o_stall  out  1  hold pipeline
- o_rdata  out  32  extended load result
- o_rdata_valid  out  1  one-cycle pulse, o_rdata is new
- o_bus_req  out  1  bus request
- o_bus_we  out  1  1 = write
- o_bus_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- o_bus_wdata  out  32  lane-replicated store data
- o_bus_wmask  out  4  byte-lane write enables
- i_bus_ack  in  1  request accepted/completed
- i_bus_rdata  in  32  read word, valid with i_bus_ack
- o_misaligned  out  1  only when LSU_MISALIGN_TRAP_EN defined

## Operation
- States: IDLE, REQ, DONE (plus ERR with macro).
- Start: in IDLE, i_valid & (i_dmem_rd_en | i_dmem_wr_en). Address, size, zero_ext, we, wdata are captured into registers; next state REQ.
- Both enables high: store wins; read ignored.
- REQ: o_bus_req=1 with registered addr/we/wdata/wmask held stable. On i_bus_ack=1 -> DONE; load data latched from i_bus_rdata that same edge.
- DONE: one cycle; o_rdata_valid=1 for loads only; -> IDLE. A new start is not accepted in DONE.
- i_bus_ack outside REQ is ignored.
- Lane select uses captured addr[1:0]. Byte: lane addr[1:0]; half: lane pair addr[1] (addr[0] ignored); word: addr[1:0] ignored.
- Load extension: byte -> bit 7 (or 0) fills [31:8]; half -> bit 15 (or 0) fills [31:16]; word unchanged.
- Store: byte -> wdata[7:0] replicated ×4, wmask = 1<<addr[1:0]; half -> wdata[15:0] replicated ×2, wmask 0011/1100; word -> wmask 1111. o_bus_wmask=0 for loads.
- o_rdata holds last load result until the next load completes; stores do not change it.
- Reset values: state IDLE, o_bus_req 0, o_bus_we 0, o_bus_addr 0, o_bus_wdata 0, o_bus_wmask 0, o_rdata 0, o_rdata_valid 0, o_stall 0, o_misaligned 0.
- Reset asserted mid-transaction: immediately IDLE, o_bus_req drops asynchronously; the outstanding access is abandoned.

## Timing
- o_stall = (IDLE & start) | REQ; combinational from inputs in IDLE, registered state otherwise. Deasserted in DONE, so the pipeline advances the cycle o_rdata_valid pulses.
- Minimum latency: start cycle T, req at T+1, ack at T+1, DONE/rdata_valid at T+2 (stall high T and T+1).
- Each extra wait cycle before ack adds one cycle of stall.
- All bus outputs registered; no combinational path from i_bus_ack to o_bus_*.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a start with half access and addr[0]=1, or word access and addr[1:0]!=0, goes IDLE -> ERR, no bus request. ERR lasts one cycle with o_misaligned=1 and o_rdata_valid=0, then IDLE; o_stall is high only in the start cycle; o_rdata unchanged.
- Undefined: no ERR state, o_misaligned port absent, misaligned accesses are force-aligned per lane rules above.

## Test plan
- Word load addr 0x104, rdata 0xDEADBEEF, ack after 2 wait cycles -> req held 3 cycles at 0x104, o_rdata=0xDEADBEEF, stall 4 cycles total.
- Byte load addr 0x203 sign-ext, rdata 0x80112233 -> o_rdata=0xFFFFFF80; same with zero_ext -> 0x00000080.
- Half store addr 0x302, wdata 0x0000ABCD -> o_bus_addr 0x300, wdata 0xABCDABCD, wmask 1100, we=1, no rdata_valid.
- rd_en and wr_en both high, byte, addr 0x1, wdata 0x5A -> write with wmask 0010, wdata 0x5A5A5A5A.
- Reset low while in REQ -> o_bus_req 0 same cycle, after release an ack is ignored and next load completes normally.
- With LSU_MISALIGN_TRAP_EN: word load addr 0x102 -> o_misaligned pulse 1 cycle, o_bus_req never asserts; without macro -> o_bus_addr 0x100.
